// File: rtl/ahbl_mem_contract_monitor.sv
// rtl/ahbl_mem_contract_monitor.sv - passive AHB-Lite monitor for per-byte read-after-write contracts
// Tracks N_SLOTS armed bytes through the bus data phase and latches the first protocol or data violation.
module ahbl_mem_contract_monitor #(
   parameter int W_ADDR         = 32,
   parameter int W_DATA         = 32,
   parameter int N_SLOTS        = 4,
   parameter int MEM_SIZE_BYTES = 256,
   localparam int W_SLOT        = (N_SLOTS > 1) ? $clog2(N_SLOTS) : 1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                hready,
   input  logic                hresp,
   input  logic                hwrite,
   input  logic [W_ADDR-1:0]   haddr,
   input  logic [1:0]          htrans,
   input  logic [2:0]          hsize,
   input  logic [W_DATA-1:0]   hwdata,
   input  logic [W_DATA-1:0]   hrdata,
   input  logic                arm_valid,
   input  logic [W_SLOT-1:0]   arm_slot,
   input  logic [W_ADDR-1:0]   arm_addr,
   output logic [N_SLOTS-1:0]  slot_armed,
   output logic [N_SLOTS-1:0]  slot_known,
   output logic                err,
   output logic [1:0]          err_kind,
   output logic [W_SLOT-1:0]   err_slot,
   output logic [W_ADDR-1:0]   err_addr,
   output logic [7:0]          err_expected,
   output logic [7:0]          err_actual,
   output logic [15:0]         check_count
);
   localparam int N_BYTES  = W_DATA / 8;
   localparam int LANE_LOG = $clog2(N_BYTES);

   localparam logic [1:0] ST_EMPTY = 2'd0;
   localparam logic [1:0] ST_ARMED = 2'd1;
   localparam logic [1:0] ST_KNOWN = 2'd2;

   function automatic logic [7:0] lane_byte(input logic [W_DATA-1:0] data,
                                            input logic [W_ADDR-1:0] addr);
      logic [W_DATA-1:0] sh;
      int unsigned       lane;
      lane = 32'(addr % W_ADDR'(N_BYTES));
      sh   = data >> (lane * 8);
      return sh[7:0];
   endfunction

   logic [1:0]        st_q [N_SLOTS];
   logic [1:0]        st_d [N_SLOTS];
   logic [W_ADDR-1:0] sa_q [N_SLOTS];
   logic [W_ADDR-1:0] sa_d [N_SLOTS];
   logic [7:0]        sb_q [N_SLOTS];
   logic [7:0]        sb_d [N_SLOTS];

   logic              dph_act_q, dph_wr_q;
   logic [W_ADDR-1:0] dph_addr_q;
   logic [2:0]        dph_size_q;

   logic              stall_q, req_wr_q, rwait_q;
   logic [1:0]        req_trans_q;
   logic [W_ADDR-1:0] req_addr_q;
   logic [2:0]        req_size_q;

   logic              err_q;
   logic [1:0]        err_kind_q;
   logic [W_SLOT-1:0] err_slot_q;
   logic [W_ADDR-1:0] err_addr_q;
   logic [7:0]        err_exp_q, err_act_q;
   logic [15:0]       cnt_q, cnt_d;

   logic              dph_done, rd_ok, wr_ok, wr_err;
   logic [W_ADDR-1:0] dph_mask;
   logic [N_SLOTS-1:0] ov;
   logic              mis_any;
   logic [W_SLOT-1:0] mis_slot;
   logic [7:0]        mis_exp, mis_act, rd_byte;
   int                n_match, cnt_sum;
   logic              v_req, v_resp, v_ill;

   always_comb begin
      dph_done = dph_act_q && hready;
      rd_ok    = dph_done && !dph_wr_q && !hresp;
      wr_ok    = dph_done && dph_wr_q && !hresp;
      wr_err   = dph_done && dph_wr_q && hresp;
      dph_mask = (W_ADDR'(1) << dph_size_q) - W_ADDR'(1);
      mis_any  = 1'b0;
      mis_slot = '0;
      mis_exp  = '0;
      mis_act  = '0;
      rd_byte  = '0;
      n_match  = 0;
      for (int s = 0; s < N_SLOTS; s++) begin
         ov[s]   = (sa_q[s] & ~dph_mask) == (dph_addr_q & ~dph_mask);
         st_d[s] = st_q[s];
         sa_d[s] = sa_q[s];
         sb_d[s] = sb_q[s];
         // Comparison always sees the pre-arm slot state; the arm then overrides the update.
         if (rd_ok && ov[s] && st_q[s] == ST_KNOWN) begin
            rd_byte = lane_byte(hrdata, sa_q[s]);
            if (rd_byte == sb_q[s]) begin
               n_match = n_match + 1;
            end else if (!mis_any) begin
               mis_any  = 1'b1;
               mis_slot = W_SLOT'(s);
               mis_exp  = sb_q[s];
               mis_act  = rd_byte;
            end
         end
         if (arm_valid && arm_slot == W_SLOT'(s)) begin
            st_d[s] = ST_ARMED;
            sa_d[s] = arm_addr;
         end else if (st_q[s] != ST_EMPTY && ov[s] && wr_ok) begin
            st_d[s] = ST_KNOWN;
            sb_d[s] = lane_byte(hwdata, sa_q[s]);
         end else if (st_q[s] != ST_EMPTY && ov[s] && wr_err) begin
            st_d[s] = ST_ARMED;
         end
      end
      cnt_sum = int'(cnt_q) + n_match;
      cnt_d   = (cnt_sum > 65535) ? 16'hFFFF : 16'(cnt_sum);

      v_req  = stall_q && (htrans != req_trans_q || hwrite != req_wr_q ||
                           haddr != req_addr_q || hsize != req_size_q);
      v_resp = (!dph_act_q && (!hready || hresp)) ||
               (hresp && hready && !rwait_q) ||
               (rwait_q && !hresp);
      v_ill  = htrans[1] && hready &&
               (htrans == 2'b01 || int'(hsize) > LANE_LOG ||
                (haddr & ((W_ADDR'(1) << hsize) - W_ADDR'(1))) != '0 ||
                haddr >= W_ADDR'(MEM_SIZE_BYTES));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int s = 0; s < N_SLOTS; s++) begin
            st_q[s] <= ST_EMPTY;
            sa_q[s] <= '0;
            sb_q[s] <= '0;
         end
         dph_act_q   <= 1'b0;
         dph_wr_q    <= 1'b0;
         dph_addr_q  <= '0;
         dph_size_q  <= '0;
         stall_q     <= 1'b0;
         req_trans_q <= '0;
         req_wr_q    <= 1'b0;
         req_addr_q  <= '0;
         req_size_q  <= '0;
         rwait_q     <= 1'b0;
         err_q       <= 1'b0;
         err_kind_q  <= '0;
         err_slot_q  <= '0;
         err_addr_q  <= '0;
         err_exp_q   <= '0;
         err_act_q   <= '0;
         cnt_q       <= '0;
      end else begin
         for (int s = 0; s < N_SLOTS; s++) begin
            st_q[s] <= st_d[s];
            sa_q[s] <= sa_d[s];
            sb_q[s] <= sb_d[s];
         end
         if (hready) begin
            dph_act_q  <= htrans[1];
            dph_wr_q   <= hwrite;
            dph_addr_q <= haddr;
            dph_size_q <= hsize;
         end
         stall_q     <= htrans[1] && !hready;
         req_trans_q <= htrans;
         req_wr_q    <= hwrite;
         req_addr_q  <= haddr;
         req_size_q  <= hsize;
         rwait_q     <= hresp && !hready;
         cnt_q       <= cnt_d;
         // Lowest kind wins when several rules break in the same cycle.
         if (!err_q && (mis_any || v_req || v_resp || v_ill)) begin
            err_q <= 1'b1;
            if (mis_any) begin
               err_kind_q <= 2'd0;
               err_slot_q <= mis_slot;
               err_addr_q <= dph_addr_q;
               err_exp_q  <= mis_exp;
               err_act_q  <= mis_act;
            end else if (v_req) begin
               err_kind_q <= 2'd1;
               err_addr_q <= req_addr_q;
            end else if (v_resp) begin
               err_kind_q <= 2'd2;
               err_addr_q <= dph_addr_q;
            end else begin
               err_kind_q <= 2'd3;
               err_addr_q <= haddr;
            end
         end
      end
   end

   always_comb begin
      for (int s = 0; s < N_SLOTS; s++) begin
         slot_armed[s] = st_q[s] != ST_EMPTY;
         slot_known[s] = st_q[s] == ST_KNOWN;
      end
   end

   assign err          = err_q;
   assign err_kind     = err_kind_q;
   assign err_slot     = err_slot_q;
   assign err_addr     = err_addr_q;
   assign err_expected = err_exp_q;
   assign err_actual   = err_act_q;
   assign check_count  = cnt_q;
endmodule

// File: tb/tb_ahbl_mem_contract_monitor.sv
// tb/tb_ahbl_mem_contract_monitor.sv - bench for ahbl_mem_contract_monitor
module tb_ahbl_mem_contract_monitor;
   localparam logic [1:0] T_IDLE = 2'b00;
   localparam logic [1:0] T_NSEQ = 2'b10;

   logic        clk = 1'b0;
   logic        rst, hready, hresp, hwrite, arm_valid;
   logic [31:0] haddr, hwdata, hrdata, arm_addr;
   logic [1:0]  htrans, arm_slot;
   logic [2:0]  hsize;
   logic [3:0]  slot_armed, slot_known;
   logic        err;
   logic [1:0]  err_kind, err_slot;
   logic [31:0] err_addr;
   logic [7:0]  err_expected, err_actual;
   logic [15:0] check_count;

   always #5 clk = ~clk;

   ahbl_mem_contract_monitor dut (
      .clk(clk), .rst(rst), .hready(hready), .hresp(hresp), .hwrite(hwrite),
      .haddr(haddr), .htrans(htrans), .hsize(hsize), .hwdata(hwdata), .hrdata(hrdata),
      .arm_valid(arm_valid), .arm_slot(arm_slot), .arm_addr(arm_addr),
      .slot_armed(slot_armed), .slot_known(slot_known), .err(err), .err_kind(err_kind),
      .err_slot(err_slot), .err_addr(err_addr), .err_expected(err_expected),
      .err_actual(err_actual), .check_count(check_count)
   );

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      arm_valid = 1'b0;
   endtask

   task automatic cyc(input logic [1:0] tr, input logic wr, input logic [31:0] a, input logic [2:0] sz,
                      input logic [31:0] wd, input logic [31:0] rd, input logic rdy, input logic resp);
      htrans = tr; hwrite = wr; haddr = a; hsize = sz;
      hwdata = wd; hrdata = rd; hready = rdy; hresp = resp;
      step();
   endtask

   task automatic arm(input logic [1:0] s, input logic [31:0] a);
      arm_valid = 1'b1; arm_slot = s; arm_addr = a;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      cyc(T_IDLE, 1'b0, 32'h0, 3'd0, 32'h0, 32'h0, 1'b1, 1'b0);
      rst = 1'b0;
   endtask

   typedef struct {
      logic        rst, armv;
      logic [1:0]  arms;
      logic [31:0] arma;
      logic [1:0]  tr;
      logic        wr;
      logic [31:0] addr;
      logic [2:0]  sz;
      logic [31:0] wd, rd;
      logic        rdy, resp;
      logic        e_err;
      logic [1:0]  e_kind;
      logic [31:0] e_addr;
      logic [1:0]  e_slot;
      logic [7:0]  e_exp, e_act;
      logic [15:0] e_cnt;
      logic [3:0]  e_armed, e_known;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input logic r, input logic av, input logic [1:0] as, input logic [31:0] aa,
                      input logic [1:0] tr, input logic wr, input logic [31:0] a, input logic [2:0] sz,
                      input logic [31:0] wd, input logic [31:0] rd, input logic rdy, input logic resp,
                      input logic ee, input logic [1:0] ek, input logic [31:0] ea, input logic [1:0] es,
                      input logic [7:0] ex, input logic [7:0] ac, input logic [15:0] ec,
                      input logic [3:0] eam, input logic [3:0] ekn);
      vec_t v;
      v.rst = r; v.armv = av; v.arms = as; v.arma = aa; v.tr = tr; v.wr = wr; v.addr = a; v.sz = sz;
      v.wd = wd; v.rd = rd; v.rdy = rdy; v.resp = resp; v.e_err = ee; v.e_kind = ek; v.e_addr = ea;
      v.e_slot = es; v.e_exp = ex; v.e_act = ac; v.e_cnt = ec; v.e_armed = eam; v.e_known = ekn;
      vecs.push_back(v);
   endtask

   // Behavioural reference state for the random run
   bit          m_arm[4], m_kn[4], n_arm[4], n_kn[4];
   logic [31:0] m_a[4], n_a[4];
   logic [7:0]  m_b[4], n_b[4];
   int          m_cnt, m_kind, m_slot;
   bit          m_err;
   logic [31:0] m_eaddr;
   logic [7:0]  m_eexp, m_eact;

   function automatic logic [7:0] byte_at(input logic [31:0] d, input logic [31:0] a);
      return 8'((d >> (8 * (a % 4))) & 32'hFF);
   endfunction

   initial begin
      bit          p_act, p_wr, q_act, q_wr, prev_rdy, in_err, done, mis, ovl;
      logic [31:0] p_addr, q_addr, wd, rd;
      logic [2:0]  q_size;
      int          p_size, nm, ms, l, r;
      logic        rdy_v, resp_v, av;
      logic [1:0]  as;
      logic [31:0] aa;
      logic [7:0]  me, ma, b;
      logic [3:0]  ea, ek;

      rst = 1'b1; arm_valid = 1'b0; arm_slot = '0; arm_addr = '0;
      htrans = T_IDLE; hwrite = 1'b0; haddr = '0; hsize = '0;
      hwdata = '0; hrdata = '0; hready = 1'b1; hresp = 1'b0;

      //  rst av as aa     tr      wr    addr     sz    wdata         rdata         rdy   resp  err k  eaddr  es ex     ac     cnt armed  known
      add(1, 0, 0, 32'h0,  T_IDLE, 0, 32'h0,   3'd0, 32'h0,        32'h0,        1, 0, 0, 0, 32'h0,  0, 8'h0,  8'h0,  0, 4'b0000, 4'b0000);
      add(0, 1, 0, 32'h13, T_IDLE, 0, 32'h0,   3'd0, 32'h0,        32'h0,        1, 0, 0, 0, 32'h0,  0, 8'h0,  8'h0,  0, 4'b0001, 4'b0000);
      add(0, 0, 0, 32'h0,  T_NSEQ, 1, 32'h10,  3'd2, 32'h0,        32'h0,        1, 0, 0, 0, 32'h0,  0, 8'h0,  8'h0,  0, 4'b0001, 4'b0000);
      add(0, 0, 0, 32'h0,  T_IDLE, 0, 32'h0,   3'd0, 32'h44332211, 32'h0,        1, 0, 0, 0, 32'h0,  0, 8'h0,  8'h0,  0, 4'b0001, 4'b0001);
      add(0, 0, 0, 32'h0,  T_NSEQ, 0, 32'h13,  3'd0, 32'h0,        32'h0,        1, 0, 0, 0, 32'h0,  0, 8'h0,  8'h0,  0, 4'b0001, 4'b0001);
      add(0, 0, 0, 32'h0,  T_IDLE, 0, 32'h0,   3'd0, 32'h0,        32'h44000000, 1, 0, 0, 0, 32'h0,  0, 8'h0,  8'h0,  1, 4'b0001, 4'b0001);
      add(1, 0, 0, 32'h0,  T_IDLE, 0, 32'h0,   3'd0, 32'h0,        32'h0,        1, 0, 0, 0, 32'h0,  0, 8'h0,  8'h0,  0, 4'b0000, 4'b0000);
      add(0, 1, 0, 32'h13, T_IDLE, 0, 32'h0,   3'd0, 32'h0,        32'h0,        1, 0, 0, 0, 32'h0,  0, 8'h0,  8'h0,  0, 4'b0001, 4'b0000);
      add(0, 0, 0, 32'h0,  T_NSEQ, 1, 32'h10,  3'd2, 32'h0,        32'h0,        1, 0, 0, 0, 32'h0,  0, 8'h0,  8'h0,  0, 4'b0001, 4'b0000);
      add(0, 0, 0, 32'h0,  T_IDLE, 0, 32'h0,   3'd0, 32'h44332211, 32'h0,        1, 0, 0, 0, 32'h0,  0, 8'h0,  8'h0,  0, 4'b0001, 4'b0001);
      add(0, 0, 0, 32'h0,  T_NSEQ, 0, 32'h13,  3'd0, 32'h0,        32'h0,        1, 0, 0, 0, 32'h0,  0, 8'h0,  8'h0,  0, 4'b0001, 4'b0001);
      add(0, 0, 0, 32'h0,  T_IDLE, 0, 32'h0,   3'd0, 32'h0,        32'h55000000, 1, 0, 1, 0, 32'h13, 0, 8'h44, 8'h55, 0, 4'b0001, 4'b0001);
      add(1, 0, 0, 32'h0,  T_IDLE, 0, 32'h0,   3'd0, 32'h0,        32'h0,        1, 0, 0, 0, 32'h0,  0, 8'h0,  8'h0,  0, 4'b0000, 4'b0000);
      add(0, 0, 0, 32'h0,  T_NSEQ, 1, 32'h1C,  3'd2, 32'h0,        32'h0,        1, 0, 0, 0, 32'h0,  0, 8'h0,  8'h0,  0, 4'b0000, 4'b0000);
      add(0, 0, 0, 32'h0,  T_NSEQ, 0, 32'h20,  3'd2, 32'h0,        32'h0,        0, 0, 0, 0, 32'h0,  0, 8'h0,  8'h0,  0, 4'b0000, 4'b0000);
      add(0, 0, 0, 32'h0,  T_NSEQ, 0, 32'h24,  3'd2, 32'h0,        32'h0,        1, 0, 1, 1, 32'h20, 0, 8'h0,  8'h0,  0, 4'b0000, 4'b0000);
      add(1, 0, 0, 32'h0,  T_IDLE, 0, 32'h0,   3'd0, 32'h0,        32'h0,        1, 0, 0, 0, 32'h0,  0, 8'h0,  8'h0,  0, 4'b0000, 4'b0000);
      add(0, 0, 0, 32'h0,  T_NSEQ, 0, 32'h08,  3'd2, 32'h0,        32'h0,        1, 0, 0, 0, 32'h0,  0, 8'h0,  8'h0,  0, 4'b0000, 4'b0000);
      add(0, 0, 0, 32'h0,  T_IDLE, 0, 32'h0,   3'd0, 32'h0,        32'h0,        1, 1, 1, 2, 32'h08, 0, 8'h0,  8'h0,  0, 4'b0000, 4'b0000);
      add(1, 0, 0, 32'h0,  T_IDLE, 0, 32'h0,   3'd0, 32'h0,        32'h0,        1, 0, 0, 0, 32'h0,  0, 8'h0,  8'h0,  0, 4'b0000, 4'b0000);
      add(0, 1, 2, 32'h30, T_IDLE, 0, 32'h0,   3'd0, 32'h0,        32'h0,        1, 0, 0, 0, 32'h0,  0, 8'h0,  8'h0,  0, 4'b0100, 4'b0000);
      add(0, 0, 0, 32'h0,  T_NSEQ, 1, 32'h30,  3'd2, 32'h0,        32'h0,        1, 0, 0, 0, 32'h0,  0, 8'h0,  8'h0,  0, 4'b0100, 4'b0000);
      add(0, 0, 0, 32'h0,  T_NSEQ, 1, 32'h30,  3'd2, 32'h000000AA, 32'h0,        1, 0, 0, 0, 32'h0,  0, 8'h0,  8'h0,  0, 4'b0100, 4'b0100);
      add(0, 0, 0, 32'h0,  T_IDLE, 0, 32'h0,   3'd0, 32'h000000BB, 32'h0,        0, 1, 0, 0, 32'h0,  0, 8'h0,  8'h0,  0, 4'b0100, 4'b0100);
      add(0, 0, 0, 32'h0,  T_IDLE, 0, 32'h0,   3'd0, 32'h000000BB, 32'h0,        1, 1, 0, 0, 32'h0,  0, 8'h0,  8'h0,  0, 4'b0100, 4'b0000);
      add(0, 0, 0, 32'h0,  T_IDLE, 0, 32'h0,   3'd0, 32'h0,        32'h0,        1, 0, 0, 0, 32'h0,  0, 8'h0,  8'h0,  0, 4'b0100, 4'b0000);
      add(1, 0, 0, 32'h0,  T_IDLE, 0, 32'h0,   3'd0, 32'h0,        32'h0,        1, 0, 0, 0, 32'h0,  0, 8'h0,  8'h0,  0, 4'b0000, 4'b0000);
      add(0, 0, 0, 32'h0,  T_NSEQ, 0, 32'h11,  3'd1, 32'h0,        32'h0,        1, 0, 1, 3, 32'h11, 0, 8'h0,  8'h0,  0, 4'b0000, 4'b0000);
      add(1, 0, 0, 32'h0,  T_IDLE, 0, 32'h0,   3'd0, 32'h0,        32'h0,        1, 0, 0, 0, 32'h0,  0, 8'h0,  8'h0,  0, 4'b0000, 4'b0000);
      add(0, 0, 0, 32'h0,  T_NSEQ, 0, 32'h100, 3'd2, 32'h0,        32'h0,        1, 0, 1, 3, 32'h100,0, 8'h0,  8'h0,  0, 4'b0000, 4'b0000);
      add(1, 0, 0, 32'h0,  T_IDLE, 0, 32'h0,   3'd0, 32'h0,        32'h0,        1, 0, 0, 0, 32'h0,  0, 8'h0,  8'h0,  0, 4'b0000, 4'b0000);
      add(0, 1, 0, 32'h13, T_IDLE, 0, 32'h0,   3'd0, 32'h0,        32'h0,        1, 0, 0, 0, 32'h0,  0, 8'h0,  8'h0,  0, 4'b0001, 4'b0000);
      add(0, 1, 1, 32'h13, T_IDLE, 0, 32'h0,   3'd0, 32'h0,        32'h0,        1, 0, 0, 0, 32'h0,  0, 8'h0,  8'h0,  0, 4'b0011, 4'b0000);
      add(0, 0, 0, 32'h0,  T_NSEQ, 1, 32'h10,  3'd2, 32'h0,        32'h0,        1, 0, 0, 0, 32'h0,  0, 8'h0,  8'h0,  0, 4'b0011, 4'b0000);
      add(0, 1, 1, 32'h13, T_IDLE, 0, 32'h0,   3'd0, 32'h44332211, 32'h0,        1, 0, 0, 0, 32'h0,  0, 8'h0,  8'h0,  0, 4'b0011, 4'b0001);
      add(0, 0, 0, 32'h0,  T_NSEQ, 0, 32'h13,  3'd0, 32'h0,        32'h0,        1, 0, 0, 0, 32'h0,  0, 8'h0,  8'h0,  0, 4'b0011, 4'b0001);
      add(0, 0, 0, 32'h0,  T_IDLE, 0, 32'h0,   3'd0, 32'h0,        32'h44000000, 1, 0, 0, 0, 32'h0,  0, 8'h0,  8'h0,  1, 4'b0011, 4'b0001);

      foreach (vecs[i]) begin
         rst = vecs[i].rst;
         arm_valid = vecs[i].armv; arm_slot = vecs[i].arms; arm_addr = vecs[i].arma;
         cyc(vecs[i].tr, vecs[i].wr, vecs[i].addr, vecs[i].sz, vecs[i].wd, vecs[i].rd,
             vecs[i].rdy, vecs[i].resp);
         chk($sformatf("row%0d err", i), err, vecs[i].e_err);
         chk($sformatf("row%0d check_count", i), check_count, vecs[i].e_cnt);
         chk($sformatf("row%0d slot_armed", i), slot_armed, vecs[i].e_armed);
         chk($sformatf("row%0d slot_known", i), slot_known, vecs[i].e_known);
         if (vecs[i].e_err) begin
            chk($sformatf("row%0d err_kind", i), err_kind, vecs[i].e_kind);
            chk($sformatf("row%0d err_addr", i), err_addr, vecs[i].e_addr);
            if (vecs[i].e_kind == 2'd0) begin
               chk($sformatf("row%0d err_slot", i), err_slot, vecs[i].e_slot);
               chk($sformatf("row%0d err_expected", i), err_expected, vecs[i].e_exp);
               chk($sformatf("row%0d err_actual", i), err_actual, vecs[i].e_act);
            end
         end
      end
      rst = 1'b0;

      // Re-arm during a completing read: compare with the old byte, then the slot is ARMED
      do_reset();
      arm(2'd0, 32'h05);
      cyc(T_IDLE, 0, 32'h0, 3'd0, 32'h0, 32'h0, 1, 0);
      cyc(T_NSEQ, 1, 32'h05, 3'd0, 32'h0, 32'h0, 1, 0);
      cyc(T_IDLE, 0, 32'h0, 3'd0, 32'h0000AB00, 32'h0, 1, 0);
      chk("rearm known before read", slot_known, 4'b0001);
      cyc(T_NSEQ, 0, 32'h04, 3'd1, 32'h0, 32'h0, 1, 0);
      arm(2'd0, 32'h05);
      cyc(T_IDLE, 0, 32'h0, 3'd0, 32'h0, 32'h0000AB00, 1, 0);
      chk("rearm count", check_count, 16'd1);
      chk("rearm known after", slot_known, 4'b0000);
      chk("rearm armed after", slot_armed, 4'b0001);
      chk("rearm err", err, 1'b0);

      // Two mismatching slots: the lower index is reported, later violations are not captured
      do_reset();
      arm(2'd3, 32'h02);
      cyc(T_IDLE, 0, 32'h0, 3'd0, 32'h0, 32'h0, 1, 0);
      arm(2'd1, 32'h02);
      cyc(T_IDLE, 0, 32'h0, 3'd0, 32'h0, 32'h0, 1, 0);
      cyc(T_NSEQ, 1, 32'h00, 3'd2, 32'h0, 32'h0, 1, 0);
      cyc(T_NSEQ, 0, 32'h00, 3'd2, 32'h005A0000, 32'h0, 1, 0);
      chk("prio known", slot_known, 4'b1010);
      cyc(T_IDLE, 0, 32'h0, 3'd0, 32'h0, 32'h00770000, 1, 0);
      cyc(T_NSEQ, 0, 32'h11, 3'd1, 32'h0, 32'h0, 1, 0);
      cyc(T_IDLE, 0, 32'h0, 3'd0, 32'h0, 32'h0, 1, 0);
      chk("prio err", err, 1'b1);
      chk("prio kind", err_kind, 2'd0);
      chk("prio slot", err_slot, 2'd1);
      chk("prio addr", err_addr, 32'h0);
      chk("prio expected", err_expected, 8'h5A);
      chk("prio actual", err_actual, 8'h77);

      // Reset while a request is stalled clears the history: changing it afterwards is legal
      do_reset();
      cyc(T_NSEQ, 0, 32'h00, 3'd2, 32'h0, 32'h0, 1, 0);
      rst = 1'b1;
      cyc(T_NSEQ, 0, 32'h40, 3'd2, 32'h0, 32'h0, 0, 0);
      rst = 1'b0;
      cyc(T_NSEQ, 0, 32'h44, 3'd2, 32'h0, 32'h0, 1, 0);
      cyc(T_IDLE, 0, 32'h0, 3'd0, 32'h0, 32'h0, 1, 0);
      chk("reset history err", err, 1'b0);

      // check_count saturation: four slots on one byte give four matches per read
      do_reset();
      for (int s = 0; s < 4; s++) begin
         arm(2'(s), 32'h13);
         cyc(T_IDLE, 0, 32'h0, 3'd0, 32'h0, 32'h0, 1, 0);
      end
      cyc(T_NSEQ, 1, 32'h10, 3'd2, 32'h0, 32'h0, 1, 0);
      cyc(T_NSEQ, 0, 32'h13, 3'd0, 32'h44332211, 32'h0, 1, 0);
      for (int i = 0; i < 100; i++) cyc(T_NSEQ, 0, 32'h13, 3'd0, 32'h0, 32'h44000000, 1, 0);
      chk("count 100 reads", check_count, 16'd400);
      for (int i = 0; i < 16300; i++) cyc(T_NSEQ, 0, 32'h13, 3'd0, 32'h0, 32'h44000000, 1, 0);
      chk("count saturated", check_count, 16'hFFFF);
      chk("count no err", err, 1'b0);

      // Randomized legal traffic against the reference model
      for (int seg = 0; seg < 4; seg++) begin
         do_reset();
         for (int s = 0; s < 4; s++) begin m_arm[s] = 0; m_kn[s] = 0; m_a[s] = '0; m_b[s] = '0; end
         m_cnt = 0; m_err = 0; m_kind = 0; m_slot = 0; m_eaddr = '0; m_eexp = '0; m_eact = '0;
         p_act = 0; p_wr = 0; p_addr = '0; p_size = 0; prev_rdy = 1; in_err = 0;
         q_act = 0; q_wr = 0; q_addr = '0; q_size = '0;
         for (int c = 0; c < 400; c++) begin
            if (prev_rdy) begin
               q_act  = $urandom_range(0, 9) < 6;
               q_wr   = 1'($urandom);
               q_size = 3'($urandom_range(0, 2));
               q_addr = 32'($urandom_range(0, 31)) & ~((32'd1 << q_size) - 32'd1);
            end
            if (!p_act) begin rdy_v = 1; resp_v = 0; end
            else if (in_err) begin rdy_v = 1; resp_v = 1; end
            else begin
               r = $urandom_range(0, 19);
               rdy_v  = (r > 4);
               resp_v = (r == 4);
            end
            wd = $urandom;
            rd = $urandom;
            if (p_act && !p_wr) begin
               for (int s = 0; s < 4; s++) begin
                  if (m_kn[s] && (m_a[s] >> p_size) == (p_addr >> p_size) && $urandom_range(0, 59) != 0) begin
                     l  = 8 * int'(m_a[s] % 4);
                     rd = (rd & ~(32'hFF << l)) | (32'(m_b[s]) << l);
                  end
               end
            end
            av = ($urandom_range(0, 5) == 0);
            as = 2'($urandom_range(0, 3));
            aa = 32'($urandom_range(0, 31));

            done = p_act && rdy_v;
            nm = 0; mis = 0; ms = 0; me = '0; ma = '0;
            for (int s = 0; s < 4; s++) begin
               ovl = (m_a[s] >> p_size) == (p_addr >> p_size);
               n_arm[s] = m_arm[s]; n_kn[s] = m_kn[s]; n_a[s] = m_a[s]; n_b[s] = m_b[s];
               if (done && !p_wr && !resp_v && m_kn[s] && ovl) begin
                  b = byte_at(rd, m_a[s]);
                  if (b == m_b[s]) nm++;
                  else if (!mis) begin mis = 1; ms = s; me = m_b[s]; ma = b; end
               end
               if (av && as == 2'(s)) begin
                  n_arm[s] = 1; n_kn[s] = 0; n_a[s] = aa;
               end else if (done && p_wr && m_arm[s] && ovl) begin
                  n_kn[s] = !resp_v;
                  if (!resp_v) n_b[s] = byte_at(wd, m_a[s]);
               end
            end
            m_cnt = (m_cnt + nm > 65535) ? 65535 : m_cnt + nm;
            if (!m_err && mis) begin
               m_err = 1; m_kind = 0; m_slot = ms; m_eaddr = p_addr; m_eexp = me; m_eact = ma;
            end
            for (int s = 0; s < 4; s++) begin
               m_arm[s] = n_arm[s]; m_kn[s] = n_kn[s]; m_a[s] = n_a[s]; m_b[s] = n_b[s];
            end

            arm_valid = av; arm_slot = as; arm_addr = aa;
            cyc(q_act ? T_NSEQ : T_IDLE, q_wr, q_addr, q_size, wd, rd, rdy_v, resp_v);

            if (p_act && !rdy_v && resp_v) in_err = 1;
            else if (rdy_v) in_err = 0;
            if (rdy_v) begin p_act = q_act; p_wr = q_wr; p_addr = q_addr; p_size = int'(q_size); end
            prev_rdy = rdy_v;

            for (int s = 0; s < 4; s++) begin ea[s] = m_arm[s]; ek[s] = m_kn[s]; end
            chk($sformatf("rnd%0d.%0d check_count", seg, c), check_count, 32'(m_cnt));
            chk($sformatf("rnd%0d.%0d slot_armed", seg, c), slot_armed, ea);
            chk($sformatf("rnd%0d.%0d slot_known", seg, c), slot_known, ek);
            chk($sformatf("rnd%0d.%0d err", seg, c), err, m_err);
            if (m_err) begin
               chk($sformatf("rnd%0d.%0d err_kind", seg, c), err_kind, 32'(m_kind));
               chk($sformatf("rnd%0d.%0d err_slot", seg, c), err_slot, 32'(m_slot));
               chk($sformatf("rnd%0d.%0d err_addr", seg, c), err_addr, m_eaddr);
               chk($sformatf("rnd%0d.%0d err_expected", seg, c), err_expected, m_eexp);
               chk($sformatf("rnd%0d.%0d err_actual", seg, c), err_actual, m_eact);
            end
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
